wb_arbiter: RTL and testbench

Writeback arbiter and scoreboard that drives the register file's single write port (rd_waddr/rd_data/rd_we). It merges the in-order pipeline result from the MEM stage with results from a long-latency unit (divider, or a load miss path) behind a valid/ready handshake. It tracks destination registers with outstanding long-latency writes, so ID can stall on RAW/WAW hazards. Sits between MEM/long-latency units and the regfile; hazard output feeds ID stall logic.

---
 rtl/wb_arbiter.sv | 115 +++++++++++
 tb/tb_wb_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter for the regfile write port: merges MEM-stage results with a
// long-latency unit and scoreboards registers with outstanding long-latency writes.
module wb_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_we_i,
    input  logic [4:0]  pipe_waddr_i,
    input  logic [31:0] pipe_data_i,
    output logic        pipe_hold_o,
    input  logic        lu_valid_i,
    input  logic [4:0]  lu_waddr_i,
    input  logic [31:0] lu_data_i,
    output logic        lu_ready_o,
    input  logic        iss_valid_i,
    input  logic [4:0]  iss_rd_i,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    input  logic [4:0]  rd_addr_i,
    output logic        hazard_o,
    output logic [31:0] busy_o,
    output logic        rd_we_o,
    output logic [4:0]  rd_waddr_o,
    output logic [31:0] rd_data_o
);
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned CW   = 4;

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic            rd_we_q, rd_we_d;
    logic [AW-1:0]   rd_waddr_q, rd_waddr_d;
    logic [DW-1:0]   rd_data_q, rd_data_d;

    logic pipe_wr;
    logic starved;
    logic lu_ready;
    logic pipe_hold;
    logic lu_acc;

    // Arbitration: a starved LU result pre-empts the pipe, otherwise the pipe wins.
    always_comb begin
        pipe_wr   = pipe_we_i && (pipe_waddr_i != '0);
        starved   = lu_valid_i && (cnt_q == CW'(STARVE_MAX));
        lu_ready  = 1'b0;
        pipe_hold = 1'b0;
        if (starved) begin
            lu_ready  = 1'b1;
            pipe_hold = pipe_wr;
        end else if (!pipe_wr) begin
            lu_ready  = lu_valid_i;
        end
        lu_acc = lu_valid_i && lu_ready;
    end

    // Next state: starve counter, write-port winner and scoreboard.
    always_comb begin
        cnt_d = '0;
        if (lu_valid_i && !lu_ready) begin
            cnt_d = (cnt_q == CW'(STARVE_MAX)) ? cnt_q : cnt_q + CW'(1);
        end

        rd_we_d    = 1'b0;
        rd_waddr_d = rd_waddr_q;
        rd_data_d  = rd_data_q;
        if (lu_acc) begin
            if (lu_waddr_i != '0) begin
                rd_we_d    = 1'b1;
                rd_waddr_d = lu_waddr_i;
                rd_data_d  = lu_data_i;
            end
        end else if (pipe_wr) begin
            rd_we_d    = 1'b1;
            rd_waddr_d = pipe_waddr_i;
            rd_data_d  = pipe_data_i;
        end

        // Set is applied after clear so a same-cycle re-issue keeps the bit.
        busy_d = busy_q;
        if (lu_acc) begin
            busy_d[lu_waddr_i] = 1'b0;
        end
        if (iss_valid_i && (iss_rd_i != '0)) begin
            busy_d[iss_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            busy_q     <= '0;
            rd_we_q    <= 1'b0;
            rd_waddr_q <= '0;
            rd_data_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            rd_we_q    <= rd_we_d;
            rd_waddr_q <= rd_waddr_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign lu_ready_o  = rst_n & lu_ready;
    assign pipe_hold_o = rst_n & pipe_hold;
    assign hazard_o    = rst_n & (busy_q[rs1_addr_i] | busy_q[rs2_addr_i] | busy_q[rd_addr_i]);
    assign busy_o      = busy_q;
    assign rd_we_o     = rd_we_q;
    assign rd_waddr_o  = rd_waddr_q;
    assign rd_data_o   = rd_data_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized scoreboard bench for wb_arbiter: a reference model predicts handshakes,
// scoreboard state and regfile writes; a monitor matches DUT writes against a queue.
module tb_wb_arbiter;
    localparam int unsigned STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pipe_we_i = 1'b0;
    logic [4:0]  pipe_waddr_i = '0;
    logic [31:0] pipe_data_i = '0;
    logic        pipe_hold_o;
    logic        lu_valid_i = 1'b0;
    logic [4:0]  lu_waddr_i = '0;
    logic [31:0] lu_data_i = '0;
    logic        lu_ready_o;
    logic        iss_valid_i = 1'b0;
    logic [4:0]  iss_rd_i = '0;
    logic [4:0]  rs1_addr_i = '0;
    logic [4:0]  rs2_addr_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        hazard_o;
    logic [31:0] busy_o;
    logic        rd_we_o;
    logic [4:0]  rd_waddr_o;
    logic [31:0] rd_data_o;

    wb_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_we_i(pipe_we_i), .pipe_waddr_i(pipe_waddr_i), .pipe_data_i(pipe_data_i),
        .pipe_hold_o(pipe_hold_o),
        .lu_valid_i(lu_valid_i), .lu_waddr_i(lu_waddr_i), .lu_data_i(lu_data_i),
        .lu_ready_o(lu_ready_o),
        .iss_valid_i(iss_valid_i), .iss_rd_i(iss_rd_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
        .hazard_o(hazard_o), .busy_o(busy_o),
        .rd_we_o(rd_we_o), .rd_waddr_o(rd_waddr_o), .rd_data_o(rd_data_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [4:0] a; logic [31:0] d; } wr_t;
    typedef struct { logic [4:0] a; logic [31:0] d; } res_t;

    wr_t  wq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state
    bit [31:0]   m_busy = '0;
    int          m_wait = 0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    bit          last_acc = 1'b0;
    bit          last_hold = 1'b0;

    // Random traffic generator state
    bit          held = 1'b0;
    bit          p_we = 1'b0;
    logic [4:0]  p_a = '0;
    logic [31:0] p_d = '0;
    bit          lu_v = 1'b0;
    logic [4:0]  lu_a = '0;
    logic [31:0] lu_d = '0;
    res_t        pend[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%08h, required 0x%08h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: every DUT write must match the oldest expected write, in its cycle.
    always begin
        @(posedge clk);
        #2;
        if (rd_we_o === 1'b1) begin
            if (wq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL wr_unexpected @cyc %0d: got write %0d/0x%08h, required none",
                         cyc, rd_waddr_o, rd_data_o);
            end else begin
                wr_t e;
                e = wq.pop_front();
                check("wr_cycle", 32'(cyc), 32'(e.cyc));
                check("wr_addr", 32'(rd_waddr_o), 32'(e.a));
                check("wr_data", rd_data_o, e.d);
            end
        end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
            wr_t e;
            e = wq.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL wr_missing @cyc %0d: got rd_we_o=%b, required write %0d/0x%08h",
                     cyc, rd_we_o, e.a, e.d);
        end
    end

    // One clock of stimulus with model prediction and checks.
    task automatic step(input bit rn, input bit pwe, input logic [4:0] pwa, input logic [31:0] pd,
                        input bit luv, input logic [4:0] lua, input logic [31:0] lud,
                        input bit iv, input logic [4:0] ird,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdd);
        bit pw, e_rdy, e_hold, e_haz, acc;
        wr_t w;
        @(negedge clk);
        rst_n = rn; pipe_we_i = pwe; pipe_waddr_i = pwa; pipe_data_i = pd;
        lu_valid_i = luv; lu_waddr_i = lua; lu_data_i = lud;
        iss_valid_i = iv; iss_rd_i = ird;
        rs1_addr_i = r1; rs2_addr_i = r2; rd_addr_i = rdd;
        #1;
        pw = pwe && (pwa != 0);
        e_rdy = 1'b0; e_hold = 1'b0; e_haz = 1'b0; acc = 1'b0;
        if (rn) begin
            e_haz = m_busy[r1] | m_busy[r2] | m_busy[rdd];
            if (luv && m_wait >= int'(STARVE_MAX)) begin
                e_rdy = 1'b1; e_hold = pw;
            end else begin
                e_rdy = luv && !pw;
            end
        end
        if (luv || !rn) check("lu_ready", 32'(lu_ready_o), 32'(e_rdy));
        check("pipe_hold", 32'(pipe_hold_o), 32'(e_hold));
        check("hazard", 32'(hazard_o), 32'(e_haz));

        if (!rn) begin
            m_busy = '0; m_wait = 0; m_addr = '0; m_data = '0;
        end else begin
            acc = luv && e_rdy;
            if (acc) begin
                if (lua != 0) begin
                    w.cyc = cyc + 1; w.a = lua; w.d = lud; wq.push_back(w);
                    m_addr = lua; m_data = lud;
                end
                m_busy[lua] = 1'b0;
            end else if (pw) begin
                w.cyc = cyc + 1; w.a = pwa; w.d = pd; wq.push_back(w);
                m_addr = pwa; m_data = pd;
            end
            m_wait = (luv && !acc) ? m_wait + 1 : 0;
            if (iv && ird != 0) m_busy[ird] = 1'b1;
            m_busy[0] = 1'b0;
        end
        last_acc = acc;
        last_hold = e_hold;

        @(posedge clk);
        #1;
        check("busy", busy_o, m_busy);
        check("rd_waddr", 32'(rd_waddr_o), 32'(m_addr));
        check("rd_data", rd_data_o, m_data);
    endtask

    task automatic idle(input logic [4:0] r1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, r1, 0, 0);
    endtask

    // One cycle of random, protocol-respecting traffic.
    task automatic rand_cycle(input int i, input bit gen);
        bit         iv;
        logic [4:0] ird, r;
        int         k;
        if (!held) begin
            p_we = gen && ($urandom_range(0, 99) < ((i < 300) ? 85 : 40));
            p_a  = 5'($urandom_range(0, 31));
            if (m_busy[p_a]) p_a = '0;
            p_d  = $urandom;
        end
        if (!lu_v) begin
            if (pend.size() > 0 && $urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, pend.size() - 1);
                lu_a = pend[k].a; lu_d = pend[k].d; pend.delete(k); lu_v = 1'b1;
            end else if (gen && $urandom_range(0, 24) == 0) begin
                lu_a = '0; lu_d = $urandom; lu_v = 1'b1;
            end
        end
        iv = 1'b0; ird = '0;
        if (gen && $urandom_range(0, 3) == 0) begin
            r = 5'($urandom_range(1, 31));
            if (!m_busy[r]) begin iv = 1'b1; ird = r; end
        end
        step(1, p_we, p_a, p_d, lu_v, lu_a, lu_d, iv, ird,
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        held = last_hold;
        if (last_acc) lu_v = 1'b0;
        if (iv) begin
            res_t p;
            p.a = ird; p.d = $urandom;
            pend.push_back(p);
        end
    endtask

    initial begin
        // Reset
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Pipe only, then x0 pipe write is dropped
        step(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 32'h00000055, 0, 0, 0, 0, 0, 0, 0, 0);
        // Scoreboard set, hazard, LU return clears
        step(1, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        step(1, 0, 0, 0, 1, 7, 32'h1234, 0, 0, 7, 0, 0);
        idle(7);
        // Contention: LU refused STARVE_MAX cycles, then pre-empts and pipe holds
        step(1, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            step(1, 1, 5'(10 + i), 32'hA000_0000 + 32'(i), 1, 9, 32'h9999, 0, 0, 0, 9, 0);
        step(1, 1, 20, 32'hB0B0B0B0, 1, 9, 32'h9999, 0, 0, 0, 9, 0);
        step(1, 1, 20, 32'hB0B0B0B0, 0, 0, 0, 0, 0, 0, 9, 0);
        // Simultaneous clear/set on x3
        step(1, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        step(1, 0, 0, 0, 1, 3, 32'h33, 1, 3, 0, 0, 3);
        step(1, 0, 0, 0, 1, 3, 32'h34, 0, 0, 0, 0, 3);
        // x0 handling
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 32'h77, 0, 0, 0, 0, 0);
        idle(0);
        // Reset mid-operation with busy=0x0F00 and an LU result pending
        for (int r = 8; r < 12; r++) step(1, 0, 0, 0, 0, 0, 0, 1, 5'(r), 0, 0, 0);
        step(0, 1, 6, 32'h66, 1, 8, 32'h88, 0, 0, 8, 9, 10);
        idle(8);
        // Randomized traffic, then drain outstanding results
        for (int i = 0; i < 800; i++) rand_cycle(i, 1'b1);
        for (int i = 0; i < 200 && (lu_v || pend.size() > 0 || held); i++) rand_cycle(i, 1'b0);
        idle(0);
        idle(0);
        check("wr_queue_drained", 32'(wq.size()), 32'd0);
        check("lu_drained", 32'(pend.size()) + 32'(lu_v), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
